// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the SRAM-port arbiter.
// Holds the arbiter state encoding, bus field types and CTI/BTE codes.
// No logic; imported by the interface, the arbiter and its bench.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } wb_state_e;

  typedef logic [2:0] cti_t;
  typedef logic [1:0] bte_t;

  localparam int DAT_WIDTH = 8;

  localparam cti_t CTI_CLASSIC = 3'b000;
  localparam cti_t CTI_CONST   = 3'b001;
  localparam cti_t CTI_INCR    = 3'b010;
  localparam cti_t CTI_END     = 3'b111;

  localparam bte_t BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_rr_watchdog_arbiter_if.sv
// One Wishbone B4 link (8-bit data) between a bus master and a slave.
// Latency: none, plain bundle of wires.
// Backpressure: carried by the ack/err/rty terminations only.
interface wb_rr_watchdog_arbiter_if
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 23
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DAT_WIDTH-1:0]  dat_w;
  logic [DAT_WIDTH-1:0]  dat_r;
  cti_t                  cti;
  bte_t                  bte;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    output cyc, stb, we, sel, adr, dat_w, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w, cti, bte,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_watchdog_timer.sv
// Saturating wait counter for one outstanding Wishbone beat.
// Latency: expired rises the cycle the count equals TIMEOUT.
// Backpressure: none; TIMEOUT=0 keeps expired low forever.
module wb_watchdog_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] wdog;

  // Count waiting cycles; stop at the limit so the count never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      wdog <= '0;
    end else if (enable && (TIMEOUT != 0) && (wdog != LIMIT)) begin
      wdog <= wdog + W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (wdog == LIMIT);

endmodule

// File: rtl/wb_rr_watchdog_arbiter.sv
// Two-port round-robin Wishbone arbiter in front of the SPI SRAM controller.
// Latency: grant one cycle after cyc, bus path and terminations combinational.
// Backpressure: loser waits with cyc high; a beat stalled TIMEOUT cycles is aborted with err.
module wb_rr_watchdog_arbiter
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 23,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  wb_rr_watchdog_arbiter_if.slave         wbs0,
  wb_rr_watchdog_arbiter_if.slave         wbs1,
  wb_rr_watchdog_arbiter_if.master        wbm,
  output logic                            timeout_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_BUSY  = BUSY;
  localparam logic [1:0] S_ABORT = ABORT;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  owner;
  logic                  last_owner;
  logic                  grant;
  logic                  any_req;
  logic                  owner_cyc;
  logic                  owner_stb;
  logic                  term;
  logic                  wdog_clear;
  logic                  wdog_en;
  logic                  wdog_expired;
  logic [ADDR_WIDTH-1:0] adr_mux;

  assign any_req   = wbs0.cyc | wbs1.cyc;
  assign owner_cyc = owner ? wbs1.cyc : wbs0.cyc;
  assign owner_stb = owner ? wbs1.stb : wbs0.stb;
  assign term      = wbm.ack | wbm.err | wbm.rty;

  // On a tie the port that did not win last time gets the bus.
  assign grant = (wbs0.cyc && wbs1.cyc) ? ~last_owner : ~wbs0.cyc;

  // The watchdog only measures beats that are actually strobed on the SRAM side.
  assign wdog_clear = (state != S_BUSY) || term;
  assign wdog_en    = (state == S_BUSY) && owner_cyc && owner_stb;

  wb_watchdog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (wdog_clear),
    .enable  (wdog_en),
    .expired (wdog_expired)
  );

  // Next-state: release on owner cyc drop, abort a stalled beat unless it terminates now.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_BUSY;
      S_BUSY: begin
        if (!owner_cyc) begin
          state_nxt = S_IDLE;
        end else if (wdog_expired && !term) begin
          state_nxt = S_ABORT;
        end
      end
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and ownership registers; both owner fields latch only on a fresh grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) begin
        owner      <= grant;
        last_owner <= grant;
      end
    end
  end

  assign adr_mux = owner ? wbs1.adr : wbs0.adr;

  // Owner request drives the SRAM port while busy; everything is quiet otherwise.
  always_comb begin
    wbm.cyc   = 1'b0;
    wbm.stb   = 1'b0;
    wbm.we    = 1'b0;
    wbm.sel   = 1'b0;
    wbm.adr   = '0;
    wbm.dat_w = '0;
    wbm.cti   = CTI_CLASSIC;
    wbm.bte   = BTE_LINEAR;
    if (state == S_BUSY) begin
      wbm.adr = adr_mux;
      if (owner) begin
        wbm.cyc   = wbs1.cyc;
        wbm.stb   = wbs1.stb;
        wbm.we    = wbs1.we;
        wbm.sel   = wbs1.sel;
        wbm.dat_w = wbs1.dat_w;
        wbm.cti   = wbs1.cti;
        wbm.bte   = wbs1.bte;
      end else begin
        wbm.cyc   = wbs0.cyc;
        wbm.stb   = wbs0.stb;
        wbm.we    = wbs0.we;
        wbm.sel   = wbs0.sel;
        wbm.dat_w = wbs0.dat_w;
        wbm.cti   = wbs0.cti;
        wbm.bte   = wbs0.bte;
      end
    end
  end

  // Terminations reach the owner only; stray responses outside BUSY are dropped.
  always_comb begin
    wbs0.ack = 1'b0;
    wbs0.err = 1'b0;
    wbs0.rty = 1'b0;
    wbs1.ack = 1'b0;
    wbs1.err = 1'b0;
    wbs1.rty = 1'b0;
    if (state == S_BUSY) begin
      if (owner) begin
        wbs1.ack = wbm.ack;
        wbs1.err = wbm.err;
        wbs1.rty = wbm.rty;
      end else begin
        wbs0.ack = wbm.ack;
        wbs0.err = wbm.err;
        wbs0.rty = wbm.rty;
      end
    end else if (state == S_ABORT) begin
      if (owner) begin
        wbs1.err = 1'b1;
      end else begin
        wbs0.err = 1'b1;
      end
    end
  end

  assign wbs0.dat_r = wbm.dat_r;
  assign wbs1.dat_r = wbm.dat_r;
  assign timeout_o  = (state == S_ABORT);

endmodule

// File: tb/tb_wb_rr_watchdog_arbiter.sv
// Directed bench for the two-port round-robin watchdog arbiter.
// One row per clock: requester/slave inputs and the expected outputs.
// Burst and reset-mid-burst corners run as hand-written sequences.
module tb_wb_rr_watchdog_arbiter;
  import wb_pkg::*;

  localparam int AW = 23;

  // expected output vector: {cyc, stb, ack0, ack1, err0, err1, rty0, rty1, timeout}
  localparam logic [8:0] BUS = 9'h180;
  localparam logic [8:0] CY  = 9'h100;
  localparam logic [8:0] K0  = 9'h040;
  localparam logic [8:0] K1  = 9'h020;
  localparam logic [8:0] E0  = 9'h010;
  localparam logic [8:0] E1  = 9'h008;
  localparam logic [8:0] R0  = 9'h004;
  localparam logic [8:0] TO  = 9'h001;
  localparam logic [8:0] Z   = 9'h000;

  // requests: {cyc0, stb0, cyc1, stb1}; responses: {ack, err, rty}
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] BOTH = 4'b1111;
  localparam logic [3:0] P0   = 4'b1100;
  localparam logic [3:0] P1   = 4'b0011;
  localparam logic [3:0] P0C  = 4'b1000;
  localparam logic [2:0] NR   = 3'b000;
  localparam logic [2:0] ACK  = 3'b100;
  localparam logic [2:0] ERR  = 3'b010;
  localparam logic [2:0] RTY  = 3'b001;

  localparam logic [37:0] P0_BUS = {23'h000100, 1'b1, 8'hA5, 1'b1, CTI_CLASSIC, BTE_LINEAR};
  localparam logic [37:0] P1_BUS = {23'h000010, 1'b0, 8'h3C, 1'b1, CTI_CONST, BTE_LINEAR};

  typedef struct {
    logic [3:0] req;
    logic [2:0] rsp;
    logic [7:0] rd;
    logic [8:0] e;
    logic       own;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic timeout;
  int   tests = 0;
  int   fails = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  wb_rr_watchdog_arbiter_if #(.ADDR_WIDTH(AW)) s0 ();
  wb_rr_watchdog_arbiter_if #(.ADDR_WIDTH(AW)) s1 ();
  wb_rr_watchdog_arbiter_if #(.ADDR_WIDTH(AW)) m ();

  wb_rr_watchdog_arbiter #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wbs0      (s0),
    .wbs1      (s1),
    .wbm       (m),
    .timeout_o (timeout)
  );

  function automatic vec_t mk(input logic [3:0] req, input logic [2:0] rsp,
                              input logic [7:0] rd, input logic [8:0] e, input logic own);
    vec_t v;
    v.req = req;
    v.rsp = rsp;
    v.rd  = rd;
    v.e   = e;
    v.own = own;
    return v;
  endfunction

  task automatic drive(input vec_t t);
    s0.cyc  = t.req[3];
    s0.stb  = t.req[2];
    s1.cyc  = t.req[1];
    s1.stb  = t.req[0];
    m.ack   = t.rsp[2];
    m.err   = t.rsp[1];
    m.rty   = t.rsp[0];
    m.dat_r = t.rd;
  endtask

  task automatic check_out(input string tag, input logic [8:0] e);
    logic [8:0] a;
    a = {m.cyc, m.stb, s0.ack, s1.ack, s0.err, s1.err, s0.rty, s1.rty, timeout};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: outputs got %b want %b", tag, a, e);
    end
  endtask

  task automatic check_bus(input string tag, input logic [37:0] e);
    logic [37:0] a;
    a = {m.adr, m.we, m.dat_w, m.sel, m.cti, m.bte};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: bus got %h want %h", tag, a, e);
    end
  endtask

  task automatic check_dat(input string tag, input logic [7:0] e);
    tests++;
    if (s0.dat_r !== e || s1.dat_r !== e) begin
      fails++;
      $display("FAIL %s: read data got %h/%h want %h", tag, s0.dat_r, s1.dat_r, e);
    end
  endtask

  initial begin
    // contention from reset: port 0 first, then strict alternation on ties
    vt.push_back(mk(BOTH, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, ACK, 8'h11, BUS | K0, 1'b0));
    vt.push_back(mk(P1,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(P1,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(P1,   NR,  8'h00, BUS,      1'b1));
    vt.push_back(mk(P1,   ACK, 8'h22, BUS | K1, 1'b1));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, RTY, 8'h00, BUS | R0, 1'b0));
    vt.push_back(mk(P1,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b1));
    vt.push_back(mk(BOTH, ERR, 8'h00, BUS | E1, 1'b1));
    vt.push_back(mk(P0,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(P0,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(P0,   ACK, 8'h33, BUS | K0, 1'b0));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    // single requester: port 1 read acked after three wait cycles
    vt.push_back(mk(P1,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(P1,   NR,  8'h00, BUS,      1'b1));
    vt.push_back(mk(P1,   NR,  8'h00, BUS,      1'b1));
    vt.push_back(mk(P1,   NR,  8'h00, BUS,      1'b1));
    vt.push_back(mk(P1,   ACK, 8'h5A, BUS | K1, 1'b1));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    // watchdog: port 0 strobes from the second row, never answered
    vt.push_back(mk(P0,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(BOTH, ACK, 8'h77, E0 | TO,  1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(BOTH, NR,  8'h00, BUS,      1'b1));
    vt.push_back(mk(BOTH, ACK, 8'h99, BUS | K1, 1'b1));
    vt.push_back(mk(P0,   NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(P0,   NR,  8'h00, Z,        1'b0));
    // boundary: one stb-low hold cycle, then ack exactly at the limit
    vt.push_back(mk(P0,   NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(P0C,  NR,  8'h00, CY,       1'b0));
    vt.push_back(mk(P0,   NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(P0,   NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(P0,   NR,  8'h00, BUS,      1'b0));
    vt.push_back(mk(P0,   ACK, 8'hC3, BUS | K0, 1'b0));
    vt.push_back(mk(NONE, NR,  8'h00, Z,        1'b0));
    vt.push_back(mk(NONE, ACK, 8'h00, Z,        1'b0));

    s0.adr = 23'h000100; s0.we = 1'b1; s0.dat_w = 8'hA5; s0.sel = 1'b1;
    s0.cti = CTI_CLASSIC; s0.bte = BTE_LINEAR;
    s1.adr = 23'h000010; s1.we = 1'b0; s1.dat_w = 8'h3C; s1.sel = 1'b1;
    s1.cti = CTI_CONST; s1.bte = BTE_LINEAR;
    drive(mk(NONE, NR, 8'h00, Z, 1'b0));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_out("reset", Z);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check_out($sformatf("vec%0d", i), vt[i].e);
      if (vt[i].e[8]) check_bus($sformatf("vec%0d_bus", i), vt[i].own ? P1_BUS : P0_BUS);
      if (vt[i].rsp[2]) check_dat($sformatf("vec%0d_dat", i), vt[i].rd);
    end

    // port 1 wins the tie (port 0 served last) and runs an 8-beat INCR burst
    @(negedge clk);
    drive(mk(BOTH, NR, 8'h00, Z, 1'b0));
    s1.cti = CTI_INCR;
    #1;
    check_out("burst_arb", Z);
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  c;
      logic [22:0] a;
      c = (i == 7) ? CTI_END : CTI_INCR;
      a = 23'h000200 + 23'(i);
      @(negedge clk);
      s1.adr  = a;
      s1.cti  = c;
      m.ack   = 1'b1;
      m.dat_r = 8'(8'h40 + i);
      #1;
      check_out($sformatf("burst_beat%0d", i), BUS | K1);
      check_bus($sformatf("burst_bus%0d", i), {a, 1'b0, 8'h3C, 1'b1, c, BTE_LINEAR});
    end
    @(negedge clk);
    s1.cyc = 1'b0; s1.stb = 1'b0; m.ack = 1'b0;
    s1.adr = 23'h000010; s1.cti = CTI_CONST;
    #1;
    check_out("burst_release", Z);
    @(negedge clk);
    #1;
    check_out("burst_gap", Z);
    @(negedge clk);
    #1;
    check_out("p0_grant", BUS);
    check_bus("p0_grant_bus", P0_BUS);

    // reset lands during beat 3 of a port 0 burst
    @(negedge clk);
    m.ack = 1'b1;
    #1;
    check_out("p0_beat1", BUS | K0);
    @(negedge clk);
    m.ack = 1'b1;
    #1;
    check_out("p0_beat2", BUS | K0);
    @(negedge clk);
    m.ack = 1'b0;
    rst = 1'b1;
    #1;
    check_out("p0_beat3_rst", BUS);
    @(negedge clk);
    rst = 1'b0;
    s1.cyc = 1'b1; s1.stb = 1'b1; m.ack = 1'b1;
    #1;
    check_out("post_rst", Z);
    @(negedge clk);
    m.ack = 1'b0;
    #1;
    check_out("post_rst_grant", BUS);
    check_bus("post_rst_bus", P0_BUS);
    @(negedge clk);
    drive(mk(NONE, NR, 8'h00, Z, 1'b0));
    #1;
    check_out("final_release", Z);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
